pipe_hazard_unit: RTL and testbench

- Parametrised decode-stage hazard unit for the pipelined MIPS core. Sits beside the control unit.
- Keeps its own scoreboard of in-flight register writers for NUM_STAGES stages after ID (EX, MEM, WB, ...).
- Produces a load-use/RAW stall plus per-operand forwarding selects for the ID-stage operand muxes.
- Generalises the fixed EX/MEM stall logic: configurable depth and load latency, forwarding, branch flush and a stall counter.

---
 rtl/pipe_hazard_unit_pkg.sv | 28 ++
 rtl/pipe_hazard_unit_sb_stage.sv | 31 +++
 rtl/pipe_hazard_unit.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// pipe_hazard_unit_pkg
// Shared definitions for the decode-stage hazard unit and the decode glue.
//   - Scoreboard entry layout: {dst, v, wr, ld}, with dst in the top REG_AW bits.
//   - FWD_RF: the forwarding-select code meaning "use the register file".
//   - opcode_e: the MIPS opcodes the decode glue uses to classify instructions.
package pipe_hazard_unit_pkg;

    // Bit positions of the control fields inside one scoreboard entry
    localparam int ENT_LD      = 0;
    localparam int ENT_WR      = 1;
    localparam int ENT_V       = 2;
    localparam int ENT_DST_LSB = 3;
    localparam int ENT_CTRL_W  = 3;

    // Forwarding select value that means "take the operand from the regfile"
    localparam int FWD_RF = 0;

    typedef enum logic [5:0] {
        OP_ALUOP = 6'h00,
        OP_LW    = 6'h23
    } opcode_e;

    // Total entry width for a given register address width
    function automatic int ent_width(input int aw);
        return aw + ENT_CTRL_W;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_sb_stage.sv
// hazard_sb_stage
// One scoreboard entry register. Each cycle it either captures the entry
// offered on d (load = 1) or becomes a bubble (all zero, so v = 0).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the entry
//   load - 1: capture d, 0: insert a bubble
//   d    - incoming entry
//   q    - registered entry
module hazard_sb_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Entry register with bubble insertion; reset forgets the producer
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= '0;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// Decode-stage hazard unit. Tracks in-flight register writers for NUM_STAGES
// stages after ID and produces a RAW/load-use stall plus forwarding selects
// for the ID operand muxes.
// Optional feature: define PIPE_HAZARD_FWD_EN to enable forwarding. Without
// it fwd_a/fwd_b stay at the regfile code and any match in stages
// 1..NUM_STAGES-1 stalls (the regfile writes first half / reads second half,
// so the last stage never needs a stall).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   id_valid          - ID holds a real instruction
//   id_rs, id_rt      - source register addresses
//   id_use_rs/_rt     - instruction actually reads rs / rt
//   id_wr, id_dst     - instruction writes register id_dst
//   id_is_load        - instruction is LW
//   ex_flush          - taken branch, squash the ID instruction
//   stall             - hold PC and IF/ID, bubble into EX
//   fwd_a, fwd_b      - operand source: 0 = regfile, k = stage k result
//   stall_cnt         - saturating count of stalled cycles
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 32,
    localparam int SEL_W           = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_is_load,
    input  logic              ex_flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int EW = ent_width(REG_AW);

    logic [NUM_STAGES:1][EW-1:0] ent;
    logic [NUM_STAGES:1]         m_a;
    logic [NUM_STAGES:1]         m_b;
    logic [EW-1:0]               push_ent;
    logic                        acc;
    logic                        stall_raw;
    logic [SEL_W-1:0]            win_a;
    logic [SEL_W-1:0]            win_b;
    logic                        ld_a;
    logic                        ld_b;

    // Only a live, non-flushed, non-stalled instruction enters the scoreboard
    assign acc      = id_valid & ~stall & ~ex_flush;
    assign push_ent = {id_dst, 1'b1, id_wr, id_is_load};

    // Scoreboard shift chain: stage 1 takes the ID instruction or a bubble,
    // later stages always advance, so the chain never freezes
    for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
        if (k == 1) begin : g_head
            hazard_sb_stage #(.W(EW)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .load (acc),
                .d    (push_ent),
                .q    (ent[k])
            );
        end else begin : g_tail
            hazard_sb_stage #(.W(EW)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .load (1'b1),
                .d    (ent[k-1]),
                .q    (ent[k])
            );
        end

        // A stage matches when it holds a real write to a nonzero register
        // that the ID instruction reads
        logic                live;
        logic [REG_AW-1:0]   dst;
        assign dst    = ent[k][ENT_DST_LSB +: REG_AW];
        assign live   = ent[k][ENT_V] & ent[k][ENT_WR] & (dst != '0) & id_valid;
        assign m_a[k] = live & id_use_rs & (dst == id_rs);
        assign m_b[k] = live & id_use_rt & (dst == id_rt);
    end

    // Youngest matching stage wins: scan oldest to youngest, last hit sticks
    always_comb begin
        win_a = SEL_W'(FWD_RF);
        win_b = SEL_W'(FWD_RF);
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (m_a[k]) begin
                win_a = SEL_W'(k);
                ld_a  = ent[k][ENT_LD];
            end
            if (m_b[k]) begin
                win_b = SEL_W'(k);
                ld_b  = ent[k][ENT_LD];
            end
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    // Stall only while the winning producer is a load whose data is not yet
    // available for forwarding
    assign stall_raw = (ld_a & (int'(win_a) < LOAD_READY_STAGE))
                     | (ld_b & (int'(win_b) < LOAD_READY_STAGE));
    assign fwd_a     = ex_flush ? SEL_W'(FWD_RF) : win_a;
    assign fwd_b     = ex_flush ? SEL_W'(FWD_RF) : win_b;
`else
    // No bypass network: wait until the producer reaches the last stage
    assign stall_raw = (|m_a[NUM_STAGES-1:1]) | (|m_b[NUM_STAGES-1:1]);
    assign fwd_a     = SEL_W'(FWD_RF);
    assign fwd_b     = SEL_W'(FWD_RF);

    logic unused_nofwd;
    assign unused_nofwd = ^{win_a, win_b, ld_a, ld_b, m_a[NUM_STAGES], m_b[NUM_STAGES]};
`endif

    assign stall = ~ex_flush & stall_raw;

    // Saturating stall counter for performance monitoring
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit
// Directed and randomized bench for pipe_hazard_unit. The reference model
// keeps a list of accepted producers tagged with their issue cycle; a
// producer's stage is simply "cycles since issue".
module tb_pipe_hazard_unit;

    localparam int REG_AW = 5;
    localparam int NS     = 3;
    localparam int LRS    = 2;
    localparam int CW     = 4;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr;
    logic [REG_AW-1:0] id_dst;
    logic              id_is_load;
    logic              ex_flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic [CW-1:0]     stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int              cyc;
        logic            wr;
        logic [REG_AW-1:0] dst;
        logic            ld;
    } prod_t;

    prod_t prods[$];
    int    cyc_now = 0;
    int    m_cnt   = 0;

`ifdef PIPE_HAZARD_FWD_EN
    int alu_st[4] = '{0, 0, 0, 0};
    int alu_fa[4] = '{1, 2, 3, 0};
`else
    int alu_st[4] = '{1, 1, 0, 0};
    int alu_fa[4] = '{0, 0, 0, 0};
`endif

    always #5 clk = ~clk;

    pipe_hazard_unit #(
        .REG_AW           (REG_AW),
        .NUM_STAGES       (NS),
        .LOAD_READY_STAGE (LRS),
        .CNT_W            (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr      (id_wr),
        .id_dst     (id_dst),
        .id_is_load (id_is_load),
        .ex_flush   (ex_flush),
        .stall      (stall),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_cnt  (stall_cnt)
    );

    // Reference model: find the youngest in-flight writer of each operand
    task automatic modelEval(output logic st, output int fa, output int fb);
        int   best_a = 0;
        int   best_b = 0;
        logic lda    = 1'b0;
        logic ldb    = 1'b0;
        logic early  = 1'b0;
        foreach (prods[i]) begin
            int age;
            age = cyc_now - prods[i].cyc;
            if (age >= 1 && age <= NS && id_valid && prods[i].wr && prods[i].dst != 0) begin
                if (id_use_rs && prods[i].dst == id_rs) begin
                    if (age < NS) early = 1'b1;
                    if (best_a == 0 || age < best_a) begin
                        best_a = age;
                        lda    = prods[i].ld;
                    end
                end
                if (id_use_rt && prods[i].dst == id_rt) begin
                    if (age < NS) early = 1'b1;
                    if (best_b == 0 || age < best_b) begin
                        best_b = age;
                        ldb    = prods[i].ld;
                    end
                end
            end
        end
`ifdef PIPE_HAZARD_FWD_EN
        st = (best_a != 0 && lda && best_a < LRS) || (best_b != 0 && ldb && best_b < LRS);
        fa = best_a;
        fb = best_b;
`else
        st = early;
        fa = 0;
        fb = 0;
`endif
        if (ex_flush) begin
            st = 1'b0;
            fa = 0;
            fb = 0;
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one ID-stage instruction and let the combinational outputs settle
    task automatic applyStimulus(input logic v, input int rs, input int rt,
                                 input logic urs, input logic urt, input logic wr,
                                 input int dst, input logic ld, input logic fl);
        id_valid   = v;
        id_rs      = REG_AW'(rs);
        id_rt      = REG_AW'(rt);
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wr      = wr;
        id_dst     = REG_AW'(dst);
        id_is_load = ld;
        ex_flush   = fl;
        #4;
    endtask

    task automatic checkOutput(input string tag);
        logic st;
        int   fa;
        int   fb;
        modelEval(st, fa, fb);
        cmp({tag, ".stall"}, 32'(stall), 32'(st));
        cmp({tag, ".fwd_a"}, 32'(fwd_a), fa);
        cmp({tag, ".fwd_b"}, 32'(fwd_b), fb);
        cmp({tag, ".cnt"}, 32'(stall_cnt), m_cnt);
    endtask

    task automatic expectConst(input string tag, input int st, input int fa, input int fb);
        cmp({tag, ".k_stall"}, 32'(stall), st);
        cmp({tag, ".k_fwd_a"}, 32'(fwd_a), fa);
        cmp({tag, ".k_fwd_b"}, 32'(fwd_b), fb);
    endtask

    // Clock edge plus model update; returns at posedge + 1
    task automatic advance();
        logic st;
        int   fa;
        int   fb;
        prod_t p;
        modelEval(st, fa, fb);
        @(posedge clk);
        #1;
        if (rst) begin
            prods.delete();
            m_cnt = 0;
        end else begin
            if (id_valid && !st && !ex_flush) begin
                p.cyc = cyc_now;
                p.wr  = id_wr;
                p.dst = id_dst;
                p.ld  = id_is_load;
                prods.push_back(p);
            end
            if (st && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        cyc_now++;
        while (prods.size() > 0 && cyc_now - prods[0].cyc > NS) void'(prods.pop_front());
    endtask

    task automatic step(input string tag);
        checkOutput(tag);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step("idle");
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        advance();
        rst = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectConst("reset", 0, 0, 0);
        cmp("reset.k_cnt", 32'(stall_cnt), 0);
        step("reset");

        // ALU dependency walks down the stages
        applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0);
        step("alu.issue");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3, 0, 1, 0, 0, 0, 0, 0);
            expectConst($sformatf("alu.t%0d", i + 1), alu_st[i], alu_fa[i], 0);
            step("alu.read");
        end

        // Load-use on operand B
        idle(3);
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 0);
        step("lw.issue");
        applyStimulus(1, 0, 5, 0, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        expectConst("lw.t1", 1, 0, 1);
`else
        expectConst("lw.t1", 1, 0, 0);
`endif
        step("lw.t1");
        applyStimulus(1, 0, 5, 0, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        expectConst("lw.t2", 0, 0, 2);
`endif
        step("lw.t2");
        applyStimulus(1, 0, 5, 0, 1, 0, 0, 0, 0);
        step("lw.t3");

        // Youngest writer wins
        idle(3);
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 0);
        step("prio.add");
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 0);
        step("prio.sub");
        applyStimulus(1, 4, 0, 1, 0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        expectConst("prio", 0, 1, 0);
`else
        expectConst("prio", 1, 0, 0);
`endif
        step("prio");

        // Writes to $0 are invisible
        idle(3);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0);
        step("r0.issue");
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0);
        expectConst("r0", 0, 0, 0);
        step("r0");

        // Flush squashes a pending load-use and its own write
        idle(3);
        applyStimulus(1, 0, 0, 0, 0, 1, 6, 1, 0);
        step("flush.lw");
        applyStimulus(1, 6, 0, 1, 0, 1, 7, 0, 1);
        expectConst("flush", 0, 0, 0);
        step("flush");
        applyStimulus(1, 7, 0, 1, 0, 0, 0, 0, 0);
        expectConst("flush.after", 0, 0, 0);
        step("flush.after");

        // Drive the counter into saturation
        idle(3);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 9, 1, 0);
            step("sat.lw");
            applyStimulus(1, 0, 9, 0, 1, 0, 0, 0, 0);
            step("sat.use1");
            applyStimulus(1, 0, 9, 0, 1, 0, 0, 0, 0);
            step("sat.use2");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cmp("sat.k_cnt", 32'(stall_cnt), (1 << CW) - 1);
        step("sat.end");

        // Reset while stalled
        idle(3);
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 0);
        step("rstmid.lw");
        applyStimulus(1, 0, 5, 0, 1, 0, 0, 0, 0);
        cmp("rstmid.k_before", 32'(stall), 1);
        checkOutput("rstmid.before");
        rst = 1'b1;
        advance();
        rst = 1'b0;
        applyStimulus(1, 0, 5, 0, 1, 0, 0, 0, 0);
        expectConst("rstmid.after", 0, 0, 0);
        cmp("rstmid.k_cnt", 32'(stall_cnt), 0);
        step("rstmid.after");

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus($urandom_range(0, 9) != 0,
                          $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            step("rand");
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
